// File: rtl/ball_ctrl.sv
// ball_ctrl: Pong ball motion and collision engine that moves an 8x8 ball once per frame tick.
// Optional feature macro BALL_SPEEDUP_EN: every 4th paddle hit raises |vx| by 1, capped at 6.
module ball_ctrl #(
    parameter int TICK_DIV    = 1666667,
    parameter int V_RES       = 480,
    parameter int H_RES       = 640,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_XL   = 600,
    parameter int PADDLE_XR   = 603,
    parameter int PADDLE_H    = 72,
    parameter int BALL_V      = 2,
    parameter int MISS_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serve,
    input  logic [9:0] paddle_top,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       hit,
    output logic       miss,
    output logic [7:0] score,
    output logic       frame_tick
);

    localparam int CNT_W  = $clog2(TICK_DIV + 1);
    localparam int MCNT_W = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;

    localparam logic [9:0] CX     = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0] CY     = 10'((V_RES - BALL_SIZE) / 2);
    localparam logic [9:0] Y_BOT  = 10'(V_RES - BALL_SIZE);
    localparam logic [9:0] X_PAD  = 10'(PADDLE_XL - BALL_SIZE);
    localparam logic [9:0] X_EDGE = 10'(H_RES - BALL_SIZE);

    localparam logic signed [11:0] S_BS1  = 12'(BALL_SIZE - 1);
    localparam logic signed [11:0] S_XL   = 12'(PADDLE_XL);
    localparam logic signed [11:0] S_XR   = 12'(PADDLE_XR);
    localparam logic signed [11:0] S_PH1  = 12'(PADDLE_H - 1);
    localparam logic signed [11:0] S_YBOT = 12'(V_RES - BALL_SIZE);
    localparam logic signed [11:0] S_V    = 12'(BALL_V);

    localparam logic [2:0] SPD_INIT = 3'(BALL_V);

    typedef enum logic [1:0] {IDLE, MOVE, MISS} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    count;
    logic [MCNT_W-1:0]   miss_cnt, miss_cnt_nxt;
    logic [2:0]          spd_x, spd_x_nxt;
    logic                vx_neg, vx_neg_nxt, vy_neg, vy_neg_nxt;
    logic [9:0]          x_nxt, y_nxt;
    logic [7:0]          score_nxt;
    logic                hit_nxt, miss_nxt;

    logic signed [11:0]  vx_s, vy_s, nx, ny, nx_r, ny_b, pt;
    logic                top_hit, bot_hit, left_hit, pad_hit, pass;
    logic                move_en, miss_done;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

`ifdef BALL_SPEEDUP_EN
    function automatic logic [2:0] spd_inc(input logic [2:0] s);
        return (s >= 3'd6) ? 3'd6 : s + 3'd1;
    endfunction
`endif

    assign frame_tick = (count == CNT_W'(TICK_DIV));
    // The serve tick already advances the ball, so IDLE+serve moves like MOVE.
    assign move_en    = frame_tick && ((state == MOVE) || ((state == IDLE) && serve));
    assign miss_done  = frame_tick && (state == MISS) && (miss_cnt == MCNT_W'(MISS_FRAMES - 1));

    // Candidate position and collision tests, widened so nothing wraps.
    always_comb begin
        vx_s     = vx_neg ? -$signed({9'd0, spd_x}) : $signed({9'd0, spd_x});
        vy_s     = vy_neg ? -S_V : S_V;
        nx       = $signed({2'b00, ball_x}) + vx_s;
        ny       = $signed({2'b00, ball_y}) + vy_s;
        nx_r     = nx + S_BS1;
        ny_b     = ny + S_BS1;
        pt       = $signed({2'b00, paddle_top});
        top_hit  = (ny <= 12'sd0);
        bot_hit  = (ny >= S_YBOT);
        left_hit = (nx <= 12'sd0);
        pad_hit  = !vx_neg && (nx_r >= S_XL) && (nx_r <= S_XR) &&
                   (ny_b >= pt) && (ny <= pt + S_PH1);
        pass     = (nx_r > S_XR) && !pad_hit;
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (move_en) state_nxt = pass ? MISS : MOVE;
            MOVE:    if (move_en && pass) state_nxt = MISS;
            MISS:    if (miss_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        x_nxt        = ball_x;
        y_nxt        = ball_y;
        vx_neg_nxt   = vx_neg;
        vy_neg_nxt   = vy_neg;
        spd_x_nxt    = spd_x;
        score_nxt    = score;
        miss_cnt_nxt = miss_cnt;
        hit_nxt      = 1'b0;
        miss_nxt     = 1'b0;
        if (move_en) begin
            if (top_hit) begin
                y_nxt      = '0;
                vy_neg_nxt = 1'b0;
            end else if (bot_hit) begin
                y_nxt      = Y_BOT;
                vy_neg_nxt = 1'b1;
            end else begin
                y_nxt = ny[9:0];
            end
            if (left_hit) begin
                x_nxt      = '0;
                vx_neg_nxt = 1'b0;
            end else if (pad_hit) begin
                x_nxt      = X_PAD;
                vx_neg_nxt = 1'b1;
                hit_nxt    = 1'b1;
                score_nxt  = sat_inc(score);
`ifdef BALL_SPEEDUP_EN
                if (score_nxt[1:0] == 2'b00) spd_x_nxt = spd_inc(spd_x);
`endif
            end else if (pass) begin
                x_nxt    = X_EDGE;
                miss_nxt = 1'b1;
            end else begin
                x_nxt = nx[9:0];
            end
            miss_cnt_nxt = '0;
        end else if (frame_tick && (state == MISS)) begin
            if (miss_done) begin
                x_nxt        = CX;
                y_nxt        = CY;
                vx_neg_nxt   = 1'b0;
                vy_neg_nxt   = 1'b1;
                spd_x_nxt    = SPD_INIT;
                miss_cnt_nxt = '0;
            end else begin
                miss_cnt_nxt = miss_cnt + MCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count    <= '0;
            ball_x   <= CX;
            ball_y   <= CY;
            vx_neg   <= 1'b0;
            vy_neg   <= 1'b0;
            spd_x    <= SPD_INIT;
            score    <= '0;
            hit      <= 1'b0;
            miss     <= 1'b0;
            miss_cnt <= '0;
        end else begin
            count    <= frame_tick ? '0 : count + CNT_W'(1);
            ball_x   <= x_nxt;
            ball_y   <= y_nxt;
            vx_neg   <= vx_neg_nxt;
            vy_neg   <= vy_neg_nxt;
            spd_x    <= spd_x_nxt;
            score    <= score_nxt;
            hit      <= hit_nxt;
            miss     <= miss_nxt;
            miss_cnt <= miss_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl with TICK_DIV=4 and MISS_FRAMES=3; follows one continuous trajectory.
module tb_ball_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       serve;
    logic [9:0] paddle_top;
    logic [9:0] ball_x, ball_y;
    logic       hit, miss;
    logic [7:0] score;
    logic       frame_tick;

    int tests = 0;
    int fails = 0;

`ifdef BALL_SPEEDUP_EN
    localparam int EXP_V4 = 3;
`else
    localparam int EXP_V4 = 2;
`endif

    ball_ctrl #(.TICK_DIV(4), .MISS_FRAMES(3)) dut (
        .clk(clk), .reset(reset), .serve(serve), .paddle_top(paddle_top),
        .ball_x(ball_x), .ball_y(ball_y), .hit(hit), .miss(miss),
        .score(score), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Returns at the negedge just after a frame tick; cyc = negedges from call to the tick.
    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!frame_tick && cyc < 20);
        if (!frame_tick) begin
            tests++; fails++;
            $display("FAIL tick_timeout: no frame_tick within %0d clk, required one within 5", cyc);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $fatal(1, "frame tick never arrived");
        end
        @(negedge clk);
    endtask

    task automatic advance(input int n);
        int cyc;
        for (int i = 0; i < n; i++) wait_tick(cyc);
    endtask

    task automatic test_reset();
        reset = 1'b0; serve = 1'b0; paddle_top = 10'd0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        tests++;
        if (ball_x !== 10'd316 || ball_y !== 10'd236) begin
            fails++; $display("FAIL reset_pos: got (%0d,%0d) want (316,236)", ball_x, ball_y);
        end
        tests++;
        if (score !== 8'd0 || hit !== 1'b0 || miss !== 1'b0 || frame_tick !== 1'b0) begin
            fails++; $display("FAIL reset_ctrl: score=%0d hit=%b miss=%b tick=%b want 0,0,0,0",
                              score, hit, miss, frame_tick);
        end
        advance(5);
        tests++;
        if (ball_x !== 10'd316 || ball_y !== 10'd236) begin
            fails++; $display("FAIL idle_hold: got (%0d,%0d) want (316,236)", ball_x, ball_y);
        end
    endtask

    task automatic test_serve();
        int cyc;
        serve = 1'b1;
        wait_tick(cyc);
        serve = 1'b0;
        tests++;
        if (ball_x !== 10'd318 || ball_y !== 10'd238) begin
            fails++; $display("FAIL serve_first: got (%0d,%0d) want (318,238)", ball_x, ball_y);
        end
        wait_tick(cyc);
        tests++;
        if (cyc + 1 != 5) begin
            fails++; $display("FAIL tick_period: got %0d clk want 5", cyc + 1);
        end
        tests++;
        if (ball_x !== 10'd320 || ball_y !== 10'd240) begin
            fails++; $display("FAIL serve_second: got (%0d,%0d) want (320,240)", ball_x, ball_y);
        end
    endtask

    task automatic test_bottom_wall();
        advance(116);
        tests++;
        if (ball_x !== 10'd552 || ball_y !== 10'd472) begin
            fails++; $display("FAIL bottom_clamp: got (%0d,%0d) want (552,472)", ball_x, ball_y);
        end
        advance(1);
        tests++;
        if (ball_x !== 10'd554 || ball_y !== 10'd470) begin
            fails++; $display("FAIL bottom_reflect: got (%0d,%0d) want (554,470)", ball_x, ball_y);
        end
    endtask

    task automatic test_paddle_hit();
        paddle_top = 10'd359;
        advance(19);
        tests++;
        if (ball_x !== 10'd592 || ball_y !== 10'd432 || hit !== 1'b0) begin
            fails++; $display("FAIL paddle_approach: got (%0d,%0d) hit=%b want (592,432) hit=0",
                              ball_x, ball_y, hit);
        end
        advance(1);
        tests++;
        if (ball_x !== 10'd592 || ball_y !== 10'd430 || hit !== 1'b1 || score !== 8'd1) begin
            fails++; $display("FAIL paddle_hit: got (%0d,%0d) hit=%b score=%0d want (592,430) hit=1 score=1",
                              ball_x, ball_y, hit, score);
        end
        @(negedge clk);
        tests++;
        if (hit !== 1'b0) begin
            fails++; $display("FAIL hit_width: hit=%b one clk later, want 0", hit);
        end
        advance(1);
        tests++;
        if (ball_x !== 10'd590 || ball_y !== 10'd428) begin
            fails++; $display("FAIL paddle_reflect: got (%0d,%0d) want (590,428)", ball_x, ball_y);
        end
    endtask

    task automatic test_top_left_walls();
        advance(214);
        tests++;
        if (ball_x !== 10'd162 || ball_y !== 10'd0) begin
            fails++; $display("FAIL top_clamp: got (%0d,%0d) want (162,0)", ball_x, ball_y);
        end
        advance(1);
        tests++;
        if (ball_x !== 10'd160 || ball_y !== 10'd2) begin
            fails++; $display("FAIL top_reflect: got (%0d,%0d) want (160,2)", ball_x, ball_y);
        end
        advance(80);
        tests++;
        if (ball_x !== 10'd0 || ball_y !== 10'd162) begin
            fails++; $display("FAIL left_clamp: got (%0d,%0d) want (0,162)", ball_x, ball_y);
        end
        advance(1);
        tests++;
        if (ball_x !== 10'd2 || ball_y !== 10'd164) begin
            fails++; $display("FAIL left_reflect: got (%0d,%0d) want (2,164)", ball_x, ball_y);
        end
    endtask

    task automatic test_miss();
        paddle_top = 10'd0;
        advance(154);
        tests++;
        if (ball_x !== 10'd310 || ball_y !== 10'd472) begin
            fails++; $display("FAIL miss_leg_bottom: got (%0d,%0d) want (310,472)", ball_x, ball_y);
        end
        advance(143);
        tests++;
        if (ball_x !== 10'd596 || ball_y !== 10'd186 || hit !== 1'b0 || miss !== 1'b0) begin
            fails++; $display("FAIL miss_edge: got (%0d,%0d) hit=%b miss=%b want (596,186) 0 0",
                              ball_x, ball_y, hit, miss);
        end
        advance(1);
        tests++;
        if (ball_x !== 10'd632 || ball_y !== 10'd184 || miss !== 1'b1 || score !== 8'd1) begin
            fails++; $display("FAIL miss_pulse: got (%0d,%0d) miss=%b score=%0d want (632,184) 1 1",
                              ball_x, ball_y, miss, score);
        end
        @(negedge clk);
        tests++;
        if (miss !== 1'b0) begin
            fails++; $display("FAIL miss_width: miss=%b one clk later, want 0", miss);
        end
        serve = 1'b1;
        advance(2);
        tests++;
        if (ball_x !== 10'd632 || ball_y !== 10'd184) begin
            fails++; $display("FAIL miss_hold: got (%0d,%0d) want (632,184)", ball_x, ball_y);
        end
        advance(1);
        tests++;
        if (ball_x !== 10'd316 || ball_y !== 10'd236) begin
            fails++; $display("FAIL miss_recentre: got (%0d,%0d) want (316,236)", ball_x, ball_y);
        end
        advance(1);
        serve = 1'b0;
        tests++;
        if (ball_x !== 10'd318 || ball_y !== 10'd234) begin
            fails++; $display("FAIL reserve_dir: got (%0d,%0d) want (318,234)", ball_x, ball_y);
        end
    endtask

    task automatic test_reset_in_move();
        int cyc;
        advance(1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tests++;
        if (ball_x !== 10'd316 || ball_y !== 10'd236 || score !== 8'd0 || frame_tick !== 1'b0) begin
            fails++; $display("FAIL reset_in_move: got (%0d,%0d) score=%0d tick=%b want (316,236) 0 0",
                              ball_x, ball_y, score, frame_tick);
        end
        wait_tick(cyc);
        tests++;
        if (cyc != 4 || ball_x !== 10'd316 || ball_y !== 10'd236) begin
            fails++; $display("FAIL reset_idle: first tick after %0d clk at (%0d,%0d) want 4 clk at (316,236)",
                              cyc, ball_x, ball_y);
        end
    endtask

    task automatic test_back_to_back();
        int  cyc;
        int  hits = 0;
        int  n = 0;
        int  exp_dx;
        bit  got_miss = 1'b0;
        serve = 1'b1;
        while (hits < 4 && n < 4000) begin
            paddle_top = (ball_y >= 10'd32) ? ball_y - 10'd32 : 10'd0;
            wait_tick(cyc);
            n++;
            serve = 1'b0;
            if (hit === 1'b1) begin
                hits++;
                tests++;
                if (ball_x !== 10'd592 || score !== 8'(hits)) begin
                    fails++; $display("FAIL b2b_hit%0d: x=%0d score=%0d want x=592 score=%0d",
                                      hits, ball_x, score, hits);
                end
                exp_dx = (hits == 4) ? EXP_V4 : 2;
                wait_tick(cyc);
                n++;
                tests++;
                if (ball_x !== 10'(592 - exp_dx)) begin
                    fails++; $display("FAIL b2b_speed%0d: x=%0d want %0d", hits, ball_x, 592 - exp_dx);
                end
            end
        end
        tests++;
        if (hits != 4) begin
            fails++; $display("FAIL b2b_hit_count: got %0d hits want 4", hits);
        end
        n = 0;
        while (!got_miss && n < 1500) begin
            paddle_top = (ball_y >= 10'd236) ? 10'd0 : 10'd400;
            wait_tick(cyc);
            n++;
            if (miss === 1'b1) got_miss = 1'b1;
        end
        tests++;
        if (!got_miss || ball_x !== 10'd632) begin
            fails++; $display("FAIL b2b_miss: miss seen=%0d x=%0d want 1 and 632", got_miss, ball_x);
        end
        advance(3);
        serve = 1'b1;
        advance(1);
        serve = 1'b0;
        tests++;
        if (ball_x !== 10'd318 || ball_y !== 10'd234 || score !== 8'd4) begin
            fails++; $display("FAIL speed_restore: got (%0d,%0d) score=%0d want (318,234) score=4",
                              ball_x, ball_y, score);
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_bottom_wall();
        test_paddle_hit();
        test_top_left_walls();
        test_miss();
        test_reset_in_move();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
